ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain driver that feeds the serial `ccff_head` → `ccff_tail` programming chain threaded through the logical IO and logic tiles. Accepts the bitstream as words over a valid/ready stream and serializes it MSB-first into the chain head, one bit per enabled `prog_clk` cycle. Holds IO isolation active (`IO_ISOL_N`=0) until a complete, optionally verified, load finishes. Sits between the SoC-side bitstream source and the fabric's configuration chain.

## Interface
- `CHAIN_LEN`, 64: total chain flops; range 2..65535.
- `WORD_W`, 8: input word width; range 1..32.
- `prog_clk  in  1`: programming clock; all state on rising edge.
- `pReset  in  1`: asynchronous, active-high reset.
- `start  in  1`: one-cycle request to begin a load; sampled only in IDLE.
- `in_data  in  WORD_W`: bitstream word, MSB shifted first.
- `in_valid  in  1`: `in_data` valid.
- `in_ready  out  1`: word accepted on edge where `in_valid && in_ready`.
- `ccff_head  out  1`: serial data into chain head.
- `ccff_tail  in  1`: serial data from chain tail.
- `chain_shift_en  out  1`: chain flops capture `ccff_head` at the next edge only when 1 (fabric gates `prog_clk` with it).
- `IO_ISOL_N  out  1`: 0 = fabric IOs isolated; 1 = released.
- `busy  out  1`: state is LOAD or VERIFY.
- `done  out  1`: load complete; level held until next accepted `start`.
- `error  out  1`: readback mismatch; level held until next accepted `start`.

## Operation
- States: IDLE, LOAD, VERIFY (only with macro), DONE.
- IDLE/DONE + `start` → LOAD; clears `done`, `error`, bit counter, CRC; `IO_ISOL_N`←0. `start` in LOAD/VERIFY ignored.
- LOAD: internal word buffer with remaining-bit count `rem`. `in_ready` = LOAD && words outstanding && (`rem`==0 || (`rem`==1 && shifting this cycle)), giving zero-bubble streaming.
- Accepted word loads buffer; `rem` = WORD_W, except the final word where `rem` = CHAIN_LEN mod WORD_W (if nonzero); unused low bits discarded.
- Each cycle with `rem`>0: `chain_shift_en`=1, `ccff_head`=buffer MSB, buffer shifts left, `rem`−1, `sent`+1. With `rem`==0 (source stall): `chain_shift_en`=0, `ccff_head`=0, `sent` unchanged.
- Words expected = ceil(CHAIN_LEN/WORD_W); no further words accepted after that.
- `sent` reaching CHAIN_LEN → VERIFY (macro) or DONE.
- DONE: `done`=1; `IO_ISOL_N`=1 unless `error`; `chain_shift_en`=0.
- Counters width clog2(CHAIN_LEN+1); no wrap permitted.

## Timing
- Reset values: `in_ready`=0, `ccff_head`=0, `chain_shift_en`=0, `IO_ISOL_N`=0, `busy`=0, `done`=0, `error`=0; state IDLE.
- `start` at edge N → `busy`=1 and `in_ready` may be 1 in cycle N+1.
- Word accepted at edge N → its first bit on `ccff_head` with `chain_shift_en`=1 in cycle N+1; `ccff_head` and `chain_shift_en` registered in LOAD.
- Last LOAD shift in cycle M → `done`=1, `IO_ISOL_N`=1 in cycle M+1 (no macro).
- Minimum load: CHAIN_LEN shift cycles plus 1 start cycle.
- `pReset` mid-load: immediate return to reset values; chain contents undefined; new `start` required.

## Configuration
- `CCFF_READBACK_EN` defined: VERIFY state lasts exactly CHAIN_LEN cycles with `chain_shift_en`=1 and `ccff_head` = `ccff_tail` combinationally (recirculation; chain contents unchanged after the pass). CRC-16 (poly 0x1021, init 0xFFFF) computed over bits sent in LOAD and over `ccff_tail` bits in VERIFY; mismatch → `error`=1, `IO_ISOL_N` stays 0. `done`=1 one cycle after last VERIFY shift either way.
- Not defined: no VERIFY state, no CRC logic, `error` tied 0, `ccff_tail` unused.

## Test plan
- CHAIN_LEN=20, WORD_W=8, words 0xA5,0x3C,0xF0 back-to-back → exactly 20 enabled shifts, serial sequence 10100101_00111100_1111, no stall cycles, `done`/`IO_ISOL_N`=1 after 20 (no macro) or 40 (macro) shift cycles.
- Same load with `in_valid` deasserted 3 cycles between words → `chain_shift_en`=0 during gaps, chain contents identical to previous case.
- Macro on, behavioral 20-flop chain model → `error`=0, `IO_ISOL_N`=1, chain holds loaded pattern after VERIFY.
- Macro on, chain model with flop 7 stuck at 0 and pattern having 1 there → `error`=1, `done`=1, `IO_ISOL_N`=0.
- `pReset` pulsed after 9 shifts → all outputs at reset values next cycle; new `start` reloads full 20 bits correctly.
- `start` pulsed mid-LOAD → ignored; shift count and `done` timing unchanged.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Serializes a word-stream bitstream MSB-first into the fabric configuration chain and holds
// IO isolation until the load (and optional readback, macro CCFF_READBACK_EN) completes.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_shift_en,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CntW     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned RemW     = $clog2(WORD_W + 1);
  localparam int unsigned NumWords = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned WordCntW = $clog2(NumWords + 1);
  localparam int unsigned LastBits = (CHAIN_LEN % WORD_W == 0) ? WORD_W : CHAIN_LEN % WORD_W;

  localparam logic [WORD_W-1:0]   LastMask  = {WORD_W{1'b1}} << (WORD_W - LastBits);
  localparam logic [CntW-1:0]     LastCnt   = CntW'(CHAIN_LEN - 1);
  localparam logic [RemW-1:0]     FullRem   = RemW'(WORD_W);
  localparam logic [RemW-1:0]     LastRem   = RemW'(LastBits);
  localparam logic [WordCntW-1:0] AllWords  = WordCntW'(NumWords);
  localparam logic [WordCntW-1:0] FinalWord = WordCntW'(NumWords - 1);

`ifdef CCFF_READBACK_EN
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StDone   = 2'd2,
    StVerify = 2'd3
  } state_e;

  // Serial CRC-16/CCITT step, polynomial 0x1021.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [RemW-1:0]     rem_q, rem_d;
  logic [CntW-1:0]     sent_q, sent_d;
  logic [WordCntW-1:0] words_q, words_d;
  logic                done_q, done_d;
  logic                head_q, head_d;
  logic                en_q, en_d;
  logic                shifting;

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_tx_q, crc_tx_d;
  logic [15:0] crc_rx_q, crc_rx_d;
  logic        error_q, error_d;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    rem_d    = rem_q;
    sent_d   = sent_q;
    words_d  = words_q;
    done_d   = done_q;
`ifdef CCFF_READBACK_EN
    crc_tx_d = crc_tx_q;
    crc_rx_d = crc_rx_q;
    error_d  = error_q;
`endif
    shifting = (state_q == StLoad) && (rem_q != '0);
    // Ready while the buffer is empty or draining its last bit: keeps the stream bubble-free.
    in_ready = (state_q == StLoad) && (words_q != AllWords) &&
               ((rem_q == '0) || ((rem_q == RemW'(1)) && shifting));

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StLoad;
          buf_d    = '0;
          rem_d    = '0;
          sent_d   = '0;
          words_d  = '0;
          done_d   = 1'b0;
`ifdef CCFF_READBACK_EN
          crc_tx_d = 16'hFFFF;
          crc_rx_d = 16'hFFFF;
          error_d  = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (shifting) begin
          buf_d  = buf_q << 1;
          rem_d  = rem_q - 1'b1;
          sent_d = sent_q + 1'b1;
`ifdef CCFF_READBACK_EN
          crc_tx_d = crc_step(crc_tx_q, buf_q[WORD_W-1]);
`endif
          if (sent_q == LastCnt) begin
`ifdef CCFF_READBACK_EN
            state_d = StVerify;
            sent_d  = '0;
`else
            state_d = StDone;
            done_d  = 1'b1;
`endif
          end
        end
        if (in_valid && in_ready) begin
          words_d = words_q + 1'b1;
          if (words_q == FinalWord) begin
            buf_d = in_data & LastMask;
            rem_d = LastRem;
          end else begin
            buf_d = in_data;
            rem_d = FullRem;
          end
        end
      end
`ifdef CCFF_READBACK_EN
      StVerify: begin
        crc_rx_d = crc_step(crc_rx_q, ccff_tail);
        sent_d   = sent_q + 1'b1;
        if (sent_q == LastCnt) begin
          state_d = StDone;
          sent_d  = '0;
          done_d  = 1'b1;
          error_d = (crc_rx_d != crc_tx_q);
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    head_d = (state_d == StLoad) ? buf_d[WORD_W-1] : 1'b0;
    en_d   = (state_d == StLoad) && (rem_d != '0);
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q  <= StIdle;
      buf_q    <= '0;
      rem_q    <= '0;
      sent_q   <= '0;
      words_q  <= '0;
      done_q   <= 1'b0;
      head_q   <= 1'b0;
      en_q     <= 1'b0;
`ifdef CCFF_READBACK_EN
      crc_tx_q <= 16'hFFFF;
      crc_rx_q <= 16'hFFFF;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      rem_q    <= rem_d;
      sent_q   <= sent_d;
      words_q  <= words_d;
      done_q   <= done_d;
      head_q   <= head_d;
      en_q     <= en_d;
`ifdef CCFF_READBACK_EN
      crc_tx_q <= crc_tx_d;
      crc_rx_q <= crc_rx_d;
      error_q  <= error_d;
`endif
    end
  end

`ifdef CCFF_READBACK_EN
  // Readback recirculates the tail into the head so the chain is left intact.
  assign ccff_head      = (state_q == StVerify) ? ccff_tail : head_q;
  assign chain_shift_en = en_q | (state_q == StVerify);
  assign busy           = (state_q == StLoad) || (state_q == StVerify);
  assign error          = error_q;
`else
  assign ccff_head      = head_q;
  assign chain_shift_en = en_q;
  assign busy           = (state_q == StLoad);
  assign error          = 1'b0;
`endif
  assign done      = done_q;
  assign IO_ISOL_N = done_q & ~error;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader (CHAIN_LEN=20, WORD_W=8) with a behavioural 20-flop chain model.
module tb_ccff_chain_loader;

  localparam int CL = 20;
`ifdef CCFF_READBACK_EN
  localparam int VerifyCyc = 20;
`else
  localparam int VerifyCyc = 0;
`endif

  logic       prog_clk = 1'b0;
  logic       pReset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, ccff_head, ccff_tail, chain_shift_en, IO_ISOL_N, busy, done, error;

  logic [CL-1:0] chain = '0;
  logic          stuck7 = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .start          (start),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ccff_head      (ccff_head),
    .ccff_tail      (ccff_tail),
    .chain_shift_en (chain_shift_en),
    .IO_ISOL_N      (IO_ISOL_N),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: flop 0 at the head, flop CL-1 drives the tail.
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) begin
    if (chain_shift_en) begin
      if (stuck7) chain <= {chain[CL-2:0], ccff_head} & ~20'h00080;
      else        chain <= {chain[CL-2:0], ccff_head};
    end
  end

  function automatic logic [15:0] crc_of(input logic [CL-1:0] bits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = CL - 1; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = (c << 1) ^ 16'h1021;
      else                 c = c << 1;
    end
    return c;
  endfunction

  // Runs one load from a negedge; returns observed shift/stall counts, done cycle and bits.
  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input int gap, input bit rnd_valid, input int start_k,
                         input int reset_after, output int shifts, output int stalls,
                         output int k_done, output logic [CL-1:0] serial,
                         output logic [CL-1:0] rb, output bit aborted);
    logic [7:0] w [3];
    int widx, gap_cnt, k;
    w[0] = w0; w[1] = w1; w[2] = w2;
    shifts = 0; stalls = 0; k_done = -1; serial = '0; rb = '0; aborted = 0;
    widx = 0; gap_cnt = 0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    k = 1;
    while (k < 300) begin
      if (done) begin
        k_done = k;
        break;
      end
      if (reset_after > 0 && shifts == reset_after) begin
        aborted = 1;
        break;
      end
      if (chain_shift_en) begin
        if (shifts < CL) serial = {serial[CL-2:0], ccff_head};
        else             rb = {rb[CL-2:0], ccff_tail};
        shifts++;
      end else if (busy) begin
        stalls++;
      end
      start = (k == start_k);
      if (gap_cnt > 0) begin
        in_valid = 1'b0;
        if (in_ready) gap_cnt--;
      end else if (widx < 3) begin
        in_valid = rnd_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = w[widx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        widx++;
        gap_cnt = gap;
      end
      @(negedge prog_clk);
      k++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    outs = {in_ready, ccff_head, chain_shift_en, IO_ISOL_N, busy, done, error};
    n_checks++;
    if (outs !== 7'b0) $display("FAIL reset_outputs: got %b want 0000000", outs);
    else n_pass++;
    @(negedge prog_clk);
    pReset = 1'b0;
    @(negedge prog_clk);
    outs = {in_ready, ccff_head, chain_shift_en, IO_ISOL_N, busy, done, error};
    n_checks++;
    if (outs !== 7'b0) $display("FAIL idle_outputs: got %b want 0000000", outs);
    else n_pass++;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    n_checks++;
    if ({busy, in_ready, chain_shift_en} !== 3'b110)
      $display("FAIL start_latency: busy/ready/en got %b want 110", {busy, in_ready, chain_shift_en});
    else n_pass++;
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    @(negedge prog_clk);
  endtask

  task automatic test_back_to_back();
    int sh, st, kd; logic [CL-1:0] ser, rb; bit ab;
    do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, -1, 0, sh, st, kd, ser, rb, ab);
    n_checks++;
    if (sh !== CL + VerifyCyc) $display("FAIL b2b_shifts: got %0d want %0d", sh, CL + VerifyCyc);
    else n_pass++;
    n_checks++;
    if (ser !== 20'hA53CF) $display("FAIL b2b_serial: got %h want a53cf", ser);
    else n_pass++;
    n_checks++;
    if (st !== 1) $display("FAIL b2b_stalls: got %0d want 1", st);
    else n_pass++;
    n_checks++;
    if (kd !== 22 + VerifyCyc) $display("FAIL b2b_done_cycle: got %0d want %0d", kd, 22 + VerifyCyc);
    else n_pass++;
    n_checks++;
    if ({done, IO_ISOL_N, error, busy, chain_shift_en} !== 5'b11000)
      $display("FAIL b2b_done_outputs: got %b want 11000",
               {done, IO_ISOL_N, error, busy, chain_shift_en});
    else n_pass++;
    n_checks++;
    if (chain !== 20'hA53CF) $display("FAIL b2b_chain: got %h want a53cf", chain);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int sh, st, kd; logic [CL-1:0] ser, rb; bit ab;
    do_load(8'hA5, 8'h3C, 8'hF0, 3, 0, -1, 0, sh, st, kd, ser, rb, ab);
    n_checks++;
    if (st !== 7) $display("FAIL gap_stalls: got %0d want 7", st);
    else n_pass++;
    n_checks++;
    if (sh !== CL + VerifyCyc) $display("FAIL gap_shifts: got %0d want %0d", sh, CL + VerifyCyc);
    else n_pass++;
    n_checks++;
    if (kd !== 28 + VerifyCyc) $display("FAIL gap_done_cycle: got %0d want %0d", kd, 28 + VerifyCyc);
    else n_pass++;
    n_checks++;
    if (chain !== 20'hA53CF) $display("FAIL gap_chain: got %h want a53cf", chain);
    else n_pass++;
  endtask

  task automatic test_start_midload();
    int sh, st, kd; logic [CL-1:0] ser, rb; bit ab;
    do_load(8'h5A, 8'hC3, 8'h0F, 0, 0, 10, 0, sh, st, kd, ser, rb, ab);
    n_checks++;
    if (kd !== 22 + VerifyCyc) $display("FAIL midstart_done_cycle: got %0d want %0d", kd, 22 + VerifyCyc);
    else n_pass++;
    n_checks++;
    if (sh !== CL + VerifyCyc) $display("FAIL midstart_shifts: got %0d want %0d", sh, CL + VerifyCyc);
    else n_pass++;
    n_checks++;
    if (chain !== 20'h5AC30) $display("FAIL midstart_chain: got %h want 5ac30", chain);
    else n_pass++;
  endtask

  task automatic test_random();
    int sh, st, kd; logic [CL-1:0] ser, rb; bit ab;
    logic [7:0] a, b, c; logic [23:0] cat; logic [CL-1:0] exp;
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      cat = {a, b, c};
      exp = cat[23:4];
      do_load(a, b, c, $urandom_range(0, 2), 1, -1, 0, sh, st, kd, ser, rb, ab);
      n_checks++;
      if (chain !== exp || ser !== exp)
        $display("FAIL rand_chain[%0d]: chain %h serial %h want %h", i, chain, ser, exp);
      else n_pass++;
      n_checks++;
      if (sh !== CL + VerifyCyc || kd < 0 || {done, IO_ISOL_N, error} !== 3'b110)
        $display("FAIL rand_finish[%0d]: shifts %0d done_k %0d d/iso/err %b want %0d,>0,110",
                 i, sh, kd, {done, IO_ISOL_N, error}, CL + VerifyCyc);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midload();
    int sh, st, kd; logic [CL-1:0] ser, rb; bit ab;
    logic [7:0] a, b, c; logic [23:0] cat; logic [6:0] outs;
    do_load(8'hFF, 8'hFF, 8'hFF, 0, 0, -1, 9, sh, st, kd, ser, rb, ab);
    n_checks++;
    if (ab !== 1'b1) $display("FAIL rst_mid_reached: aborted %0d want 1", ab);
    else n_pass++;
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    outs = {in_ready, ccff_head, chain_shift_en, IO_ISOL_N, busy, done, error};
    n_checks++;
    if (outs !== 7'b0) $display("FAIL rst_mid_outputs: got %b want 0000000", outs);
    else n_pass++;
    @(negedge prog_clk);
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    cat = {a, b, c};
    do_load(a, b, c, 0, 0, -1, 0, sh, st, kd, ser, rb, ab);
    n_checks++;
    if (chain !== cat[23:4] || kd !== 22 + VerifyCyc)
      $display("FAIL rst_mid_reload: chain %h done_k %0d want %h, %0d",
               chain, kd, cat[23:4], 22 + VerifyCyc);
    else n_pass++;
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_stuck();
    int sh, st, kd; logic [CL-1:0] ser, rb; bit ab; logic exp_err;
    stuck7 = 1'b1;
    do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, -1, 0, sh, st, kd, ser, rb, ab);
    exp_err = (crc_of(20'hA53CF) != crc_of(rb));
    n_checks++;
    if (rb === 20'hA53CF) $display("FAIL stuck_readback: got %h, fault not visible", rb);
    else n_pass++;
    n_checks++;
    if ({done, error, IO_ISOL_N} !== {1'b1, exp_err, ~exp_err} || kd !== 42)
      $display("FAIL stuck_result: done/err/iso %b done_k %0d want %b, 42",
               {done, error, IO_ISOL_N}, kd, {1'b1, exp_err, ~exp_err});
    else n_pass++;
    stuck7 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_start_midload();
    test_random();
    test_reset_midload();
`ifdef CCFF_READBACK_EN
    test_stuck();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
